// File: rtl/infer_bram_core_pkg.sv
// Shared helpers for infer_bram_core: integer log2 and the parameter legality check.
// Evaluated at elaboration time only; nothing here becomes hardware.
package infer_bram_core_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_legal(
        input int bram_size,
        input int bram_width,
        input int io_width,
        input int addr_offset
    );
        if (bram_size < 1)                              return 1'b0;
        if (bram_width <= 0 || (bram_width % 8) != 0)   return 1'b0;
        if (io_width <= 0 || (io_width % 8) != 0)       return 1'b0;
        if (io_width > bram_width)                      return 1'b0;
        if ((bram_width % io_width) != 0)               return 1'b0;
        if (!is_pow2(bram_width / io_width))            return 1'b0;
        // The offset field must at least cover every byte of one line.
        if (addr_offset < clog2(bram_width / 8))        return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/infer_bram_core.sv
// Single-port, byte-write-enabled RAM coded for block RAM inference.
// One-cycle registered read, read-first on collisions; reset clears only the read data.
module infer_bram_core
    import infer_bram_core_pkg::*;
#(
    parameter int BRAM_SIZE    = 9,
    parameter int BRAM_WIDTH   = 256,
    parameter int IO_DAT_WIDTH = 256,
    parameter int ADDR_OFFSET  = 5
) (
    input  logic                          ram_clk,
    input  logic                          ram_rstn,
    input  logic                          ram_en,
    input  logic [IO_DAT_WIDTH/8-1:0]     ram_we,
    input  logic [BRAM_SIZE+ADDR_OFFSET-1:0] ram_addr,
    input  logic [IO_DAT_WIDTH-1:0]       ram_wrdata,
    output logic [IO_DAT_WIDTH-1:0]       ram_rddata
);

    localparam bit PARAMS_OK = params_legal(BRAM_SIZE, BRAM_WIDTH, IO_DAT_WIDTH, ADDR_OFFSET);
    localparam int DEPTH     = 2 ** BRAM_SIZE;
    localparam int ADDR_W    = BRAM_SIZE + ADDR_OFFSET;
    localparam int RATIO     = BRAM_WIDTH / IO_DAT_WIDTH;
    localparam int IO_BYTES  = IO_DAT_WIDTH / 8;
    localparam int SUB_LSB   = clog2(IO_BYTES);
    localparam int SUB_W     = clog2(RATIO);
    localparam int LANE_W    = (SUB_W > 0) ? SUB_W : 1;

    generate
        if (!PARAMS_OK) begin : g_param_error
            $error("infer_bram_core: illegal BRAM_WIDTH/IO_DAT_WIDTH/ADDR_OFFSET combination");
        end
    endgenerate

    logic [BRAM_SIZE-1:0]    w_line;
    logic [LANE_W-1:0]       w_lane;
    logic                    w_addr_unused;

    logic [BRAM_WIDTH-1:0]   r_mem [DEPTH];
    logic [IO_DAT_WIDTH-1:0] r_rd_data;
    logic                    r_rd_valid;

    assign w_line = ram_addr[ADDR_W-1:ADDR_OFFSET];

    generate
        if (RATIO > 1) begin : g_lane_sel
            assign w_lane = ram_addr[SUB_LSB +: LANE_W];
        end else begin : g_lane_zero
            assign w_lane = '0;
        end
    endgenerate

    // Byte offsets and any gap below the line index are don't-care.
    assign w_addr_unused = ^ram_addr;

    // Array and read port share one reset-free process so the tools map it onto BRAM.
    always_ff @(posedge ram_clk) begin
        if (ram_en) begin
            for (int l = 0; l < RATIO; l++) begin
                for (int b = 0; b < IO_BYTES; b++) begin
                    if ((int'(w_lane) == l) && ram_we[b]) begin
                        r_mem[w_line][l*IO_DAT_WIDTH + 8*b +: 8] <= ram_wrdata[8*b +: 8];
                    end
                end
            end
            r_rd_data <= r_mem[w_line][int'(w_lane)*IO_DAT_WIDTH +: IO_DAT_WIDTH];
        end
    end

    // Reset cannot reach the BRAM output latch, so a separately reset qualifier
    // zeroes the read data asynchronously and keeps it zero until a post-reset read.
    always_ff @(posedge ram_clk or negedge ram_rstn) begin
        if (!ram_rstn) begin
            r_rd_valid <= 1'b0;
        end else if (ram_en) begin
            r_rd_valid <= 1'b1;
        end
    end

    assign ram_rddata = r_rd_valid ? r_rd_data : '0;

endmodule

// File: tb/tb_infer_bram_core.sv
// Directed bench for infer_bram_core: a full-width 256-bit instance and a 64-bit
// narrow-port instance over 256-bit lines, checked against hand-computed values.
module tb_infer_bram_core;

    logic         clk;

    logic         a_rstn;
    logic         a_en;
    logic [31:0]  a_we;
    logic [13:0]  a_addr;
    logic [255:0] a_wrdata;
    logic [255:0] a_rddata;

    logic         b_rstn;
    logic         b_en;
    logic [7:0]   b_we;
    logic [13:0]  b_addr;
    logic [63:0]  b_wrdata;
    logic [63:0]  b_rddata;

    int checks_cnt;
    int errors_cnt;

    infer_bram_core #(
        .BRAM_SIZE   (9),
        .BRAM_WIDTH  (256),
        .IO_DAT_WIDTH(256),
        .ADDR_OFFSET (5)
    ) u_dut_wide (
        .ram_clk   (clk),
        .ram_rstn  (a_rstn),
        .ram_en    (a_en),
        .ram_we    (a_we),
        .ram_addr  (a_addr),
        .ram_wrdata(a_wrdata),
        .ram_rddata(a_rddata)
    );

    infer_bram_core #(
        .BRAM_SIZE   (9),
        .BRAM_WIDTH  (256),
        .IO_DAT_WIDTH(64),
        .ADDR_OFFSET (5)
    ) u_dut_narrow (
        .ram_clk   (clk),
        .ram_rstn  (b_rstn),
        .ram_en    (b_en),
        .ram_we    (b_we),
        .ram_addr  (b_addr),
        .ram_wrdata(b_wrdata),
        .ram_rddata(b_rddata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks_cnt = checks_cnt + 1;
        if (got !== exp) begin
            errors_cnt = errors_cnt + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, return on the next falling edge.
    task automatic a_op(input logic en, input logic [31:0] we, input logic [8:0] line,
                        input logic [255:0] data);
        a_en     = en;
        a_we     = we;
        a_addr   = {line, 5'b0};
        a_wrdata = data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic b_op(input logic en, input logic [7:0] we, input logic [13:0] addr,
                        input logic [63:0] data);
        b_en     = en;
        b_we     = we;
        b_addr   = addr;
        b_wrdata = data;
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        a_rstn = 1'b0; a_en = 1'b0; a_we = '0; a_addr = '0; a_wrdata = '0;
        b_rstn = 1'b0; b_en = 1'b0; b_we = '0; b_addr = '0; b_wrdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_wide", a_rddata, 256'h0);
        check("reset_narrow", {192'h0, b_rddata}, 256'h0);
        a_rstn = 1'b1;
        b_rstn = 1'b1;
        @(negedge clk);

        // Basic write then read of line 3
        a_op(1'b1, ALL, 9'd3, {32{8'hA5}});
        a_op(1'b1, 32'h0, 9'd3, 256'h0);
        check("basic_rd_line3", a_rddata, {32{8'hA5}});

        // Byte mask on line 7
        a_op(1'b1, ALL, 9'd7, 256'h0);
        a_op(1'b1, 32'h0000_0001, 9'd7, {32{8'hFF}});
        a_op(1'b1, 32'h8000_0000, 9'd7, {32{8'hFF}});
        a_op(1'b1, 32'h0, 9'd7, 256'h0);
        check("byte_mask_line7", a_rddata, {8'hFF, 240'h0, 8'hFF});

        // Read-first collision on line 5
        a_op(1'b1, ALL, 9'd5, {32{8'h11}});
        a_op(1'b1, ALL, 9'd5, {32{8'h22}});
        check("collision_old", a_rddata, {32{8'h11}});
        a_op(1'b1, 32'h0, 9'd5, 256'h0);
        check("collision_new", a_rddata, {32{8'h22}});

        // Enable gating and extreme lines
        a_op(1'b1, ALL, 9'd511, {32{8'h33}});
        a_op(1'b1, ALL, 9'd0, {32{8'h44}});
        a_op(1'b1, 32'h0, 9'd0, 256'h0);
        check("line0_rd", a_rddata, {32{8'h44}});
        a_op(1'b0, ALL, 9'd511, {32{8'h99}});
        check("en_low_hold", a_rddata, {32{8'h44}});
        a_op(1'b1, 32'h0, 9'd511, 256'h0);
        check("line511_unchanged", a_rddata, {32{8'h33}});
        a_op(1'b1, 32'h0, 9'd0, 256'h0);
        check("line0_again", a_rddata, {32{8'h44}});

        // Asynchronous reset mid-cycle, with a write landing during reset
        a_op(1'b1, 32'h0, 9'd5, 256'h0);
        check("pre_reset_rd", a_rddata, {32{8'h22}});
        #2 a_rstn = 1'b0;
        #1 check("async_reset_now", a_rddata, 256'h0);
        a_en = 1'b1; a_we = ALL; a_addr = {9'd9, 5'b0}; a_wrdata = {32{8'h55}};
        @(posedge clk);
        @(negedge clk);
        check("reset_edge_rd_lost", a_rddata, 256'h0);
        a_rstn = 1'b1;
        a_op(1'b0, 32'h0, 9'd9, 256'h0);
        check("post_release_idle", a_rddata, 256'h0);
        a_op(1'b1, 32'h0, 9'd9, 256'h0);
        check("write_during_reset", a_rddata, {32{8'h55}});

        // Narrow port: line 2, lanes in addr[4:3]
        b_op(1'b1, 8'hFF, {9'd2, 2'd0, 3'd0}, 64'h1111_1111_1111_1111);
        b_op(1'b1, 8'hFF, {9'd2, 2'd1, 3'd0}, 64'h2222_2222_2222_2222);
        b_op(1'b1, 8'hFF, {9'd2, 2'd2, 3'd0}, 64'h3333_3333_3333_3333);
        b_op(1'b1, 8'hFF, {9'd2, 2'd3, 3'd0}, 64'h4444_4444_4444_4444);
        b_op(1'b1, 8'hFF, {9'd2, 2'd2, 3'd0}, 64'hDEAD_BEEF_CAFE_F00D);
        b_op(1'b1, 8'h00, {9'd2, 2'd2, 3'd0}, 64'h0);
        check("narrow_lane2", {192'h0, b_rddata}, {192'h0, 64'hDEAD_BEEF_CAFE_F00D});
        b_op(1'b1, 8'h00, {9'd2, 2'd0, 3'd5}, 64'h0);
        check("narrow_lane0", {192'h0, b_rddata}, {192'h0, 64'h1111_1111_1111_1111});
        b_op(1'b1, 8'h00, {9'd2, 2'd1, 3'd0}, 64'h0);
        check("narrow_lane1", {192'h0, b_rddata}, {192'h0, 64'h2222_2222_2222_2222});
        b_op(1'b1, 8'h00, {9'd2, 2'd3, 3'd0}, 64'h0);
        check("narrow_lane3", {192'h0, b_rddata}, {192'h0, 64'h4444_4444_4444_4444});
        b_op(1'b1, 8'h0F, {9'd2, 2'd1, 3'd0}, 64'hAAAA_AAAA_AAAA_AAAA);
        b_op(1'b1, 8'h00, {9'd2, 2'd1, 3'd0}, 64'h0);
        check("narrow_lane1_mask", {192'h0, b_rddata}, {192'h0, 64'h2222_2222_AAAA_AAAA});

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/infer_bram_core.md
Name: infer_bram_core

Overview:
- Generic single-port, byte-write-enabled block RAM wrapper written so FPGA synthesis infers BRAM.
- Used as the backing store for wide L1/L2 data arrays, e.g. data_arrays_0_ext (256-bit) and data_arrays_0_0_ext (128-bit, 32-bit mask replicated to bytes).
- One clock, synchronous read with one-cycle latency, per-byte write enables.
- Byte-style address; the line index sits above a fixed offset field.

Parameters:
- BRAM_SIZE, 9: log2 of line count; depth = 2**BRAM_SIZE lines.
- BRAM_WIDTH, 256: line width in bits; multiple of 8.
- IO_DAT_WIDTH, 256: port data width in bits.
  - Must divide BRAM_WIDTH; the ratio BRAM_WIDTH/IO_DAT_WIDTH is a power of two.
  - Must be a multiple of 8.
- ADDR_OFFSET, 5: number of low address bits below the line index.
  - Must satisfy ADDR_OFFSET >= log2(BRAM_WIDTH/8).

Ports:
- ram_clk  in  1: clock; all state updates on the rising edge.
- ram_rstn  in  1: asynchronous active-low reset; clears the read-data register only.
- ram_en  in  1: access enable; no read or write when low.
- ram_we  in  IO_DAT_WIDTH/8: byte write enables; bit i covers ram_wrdata[8i+7:8i].
- ram_addr  in  BRAM_SIZE+ADDR_OFFSET: byte-style address.
- ram_wrdata  in  IO_DAT_WIDTH: write data.
- ram_rddata  out  IO_DAT_WIDTH: registered read data.

Behaviour:
- Derived constants:
  - RATIO = BRAM_WIDTH/IO_DAT_WIDTH.
  - SUB_LSB = log2(IO_DAT_WIDTH/8).
  - SUB_W = log2(RATIO).
- Address decode:
  - line = ram_addr[BRAM_SIZE+ADDR_OFFSET-1 : ADDR_OFFSET].
  - lane = ram_addr[SUB_LSB +: SUB_W]; lane is 0 when RATIO==1.
  - All other low address bits are ignored.
- Storage: 2**BRAM_SIZE x BRAM_WIDTH array. No reset, no initialisation; reads before the first write return undefined data.
- Write: on a rising edge with ram_en=1, each set ram_we[i] writes byte i of ram_wrdata into byte (lane*IO_DAT_WIDTH/8 + i) of mem[line]. Unselected bytes and lanes are unchanged.
- Read: on every rising edge with ram_en=1, rd_q <= lane `lane` of mem[line].
  - This happens whether or not any ram_we bit is set.
  - Read-first: a simultaneous write to the same line returns the pre-write contents.
  - Written data is visible on the next access.
- ram_rddata = rd_q. Latency is exactly one cycle from the address edge.
- ram_en=0: memory and rd_q both hold.
- Reset: ram_rstn=0 forces rd_q to 0 immediately, independent of the clock, and holds it at 0 while asserted. Memory contents are untouched.
- Access and reset together:
  - An access whose clock edge falls while reset is asserted still performs its write.
  - The read-data update for that edge is lost; rd_q stays 0.
- Coding for inference:
  - Memory write and read in a single clocked process with no reset on the array.
  - Output register in a separate process with the asynchronous reset.
  - Byte enables as a for-loop over lanes and bytes.

Decomposition:
- Shared package: a clog2 function and an elaboration-time parameter-legality check. Illegal widths, a non-power-of-two ratio, or ADDR_OFFSET too small stop elaboration with an error.
- No sub-module; a single flat module is the natural unit.

Test Plan:
- Basic write/read: BRAM_WIDTH=IO=256, all we=1, write 0xA5..A5 to line 3 (addr=3<<5). Next cycle read line 3 with we=0 -> ram_rddata=0xA5..A5 one cycle after the address edge.
- Byte mask:
  - Preload line 7 with all 0x00.
  - Write 0xFF..FF with we=32'h0000_0001, then again with we=32'h8000_0000.
  - Read line 7 -> 0xFF00..00FF.
- Read-first collision:
  - Line 5 holds 0x11..11.
  - Same-edge write of 0x22..22 to line 5 -> rddata=0x11..11.
  - A following read -> 0x22..22.
- Enable gating:
  - ram_en=0 with all we=1 and new data/address -> memory unchanged, rddata holds its previous value.
  - Last line (511) and line 0 both read back correctly.
- Async reset: with rddata=0x22..22, drop ram_rstn mid-cycle -> rddata=0 before the next edge. It stays 0 until release and the next enabled read.
- Narrow port: BRAM_WIDTH=256, IO=64, ADDR_OFFSET=5.
  - Write 0xDEADBEEF_CAFEF00D at addr=(2<<5)|(2<<3).
  - Read the same address -> that value.
  - Read lanes 0, 1, 3 of line 2 -> previous contents, unchanged.
